// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared types and default widths for the APB master slice.
//                - apb_master_state_t : master FSM state encoding
//                - APB_ADDR_W / APB_DATA_W : default bus widths
//                - apb_rsp_t : response bundle (rdata, err, timeout)
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_master_state_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb_master_timer.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_timer
//  Description : Saturating ACCESS-phase wait counter. o_expired flags the
//                last permitted wait cycle (count == TIMEOUT_CYCLES-1).
//                TIMEOUT_CYCLES = 0 removes the counter; o_expired stays 0.
//  Ports       : i_clk      - clock, rising edge
//                i_reset_n  - asynchronous active-low reset
//                i_clear    - synchronous clear to zero (priority over enable)
//                i_enable   - count one wait cycle
//                o_expired  - count has reached TIMEOUT_CYCLES-1
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timer
      localparam int            CW     = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);
      localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT_CYCLES);

      logic [CW-1:0] r_count;

      // Holds at C_MAX rather than wrapping back to a small value.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_count <= '0;
        end else if (i_clear) begin
          r_count <= '0;
        end else if (i_enable && (r_count != C_MAX)) begin
          r_count <= r_count + CW'(1);
        end
      end

      assign o_expired = (r_count == C_LAST);
    end else begin : g_no_timer
      logic w_unused;
      assign w_unused  = i_clk ^ i_reset_n ^ i_clear ^ i_enable;
      assign o_expired = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master
//  Description : valid/ready command port to APB bridge. One transfer in
//                flight; SETUP -> ACCESS -> RESP -> IDLE, with an optional
//                ACCESS-phase timeout for slaves that never raise PREADY.
//  Ports       : i_clk, i_reset_n          - clock / async active-low reset
//                i_cmd_* / o_cmd_ready      - command request channel
//                o_rsp_* / i_rsp_ready      - buffered response channel
//                PADDR..PENABLE             - APB requester outputs
//                PRDATA, PREADY, PSLVERR    - APB completer inputs
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_W,
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic                  i_cmd_write,
  input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PSELx,
  output logic                  PENABLE,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_master_state_t r_state;
  apb_master_state_t w_next_state;

  logic w_load;
  logic w_cap_done;
  logic w_cap_timeout;
  logic w_timer_clear;
  logic w_timer_en;
  logic w_expired;

  apb_master_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // PSELx/PENABLE decode straight from the state register, so the async
  // reset of r_state drops the bus in the same cycle.
  always_comb begin
    w_next_state  = r_state;
    w_load        = 1'b0;
    w_cap_done    = 1'b0;
    w_cap_timeout = 1'b0;
    w_timer_clear = 1'b0;
    w_timer_en    = 1'b0;
    o_cmd_ready   = 1'b0;
    o_rsp_valid   = 1'b0;
    PSELx         = 1'b0;
    PENABLE       = 1'b0;
    case (r_state)
      IDLE: begin
        o_cmd_ready = i_reset_n;
        if (i_cmd_valid && i_reset_n) begin
          w_load       = 1'b1;
          w_next_state = SETUP;
        end
      end
      SETUP: begin
        PSELx         = 1'b1;
        w_timer_clear = 1'b1;
        w_next_state  = ACCESS;
      end
      ACCESS: begin
        PSELx      = 1'b1;
        PENABLE    = 1'b1;
        w_timer_en = ~PREADY;
        if (PREADY) begin
          w_cap_done   = 1'b1;
          w_next_state = RESP;
        end else if (w_expired) begin
          w_cap_timeout = 1'b1;
          w_next_state  = RESP;
        end
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Address/direction/data load only on command acceptance, so they are
  // stable across SETUP/ACCESS and keep their last value while idle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      PADDR         <= '0;
      PWRITE        <= 1'b0;
      PWDATA        <= '0;
      o_rsp_rdata   <= '0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;
    end else begin
      if (w_load) begin
        PADDR  <= i_cmd_addr;
        PWRITE <= i_cmd_write;
        PWDATA <= i_cmd_wdata;
      end
      if (w_cap_done) begin
        o_rsp_rdata   <= PWRITE ? '0 : PRDATA;
        o_rsp_err     <= PSLVERR;
        o_rsp_timeout <= 1'b0;
      end else if (w_cap_timeout) begin
        o_rsp_rdata   <= '0;
        o_rsp_err     <= 1'b1;
        o_rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master
//  Description : Directed self-checking bench for apb_master. The bench acts
//                as both requester and APB slave; inputs change and outputs
//                are sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [AW-1:0] i_cmd_addr;
  logic          i_cmd_write;
  logic [DW-1:0] i_cmd_wdata;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_rsp_err;
  logic          o_rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PSELx;
  logic          PENABLE;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int total = 0;
  int bad   = 0;
  int n_access;

  always #5 i_clk = ~i_clk;

  apb_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_write   (i_cmd_write),
    .i_cmd_wdata   (i_cmd_wdata),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_err     (o_rsp_err),
    .o_rsp_timeout (o_rsp_timeout),
    .PADDR         (PADDR),
    .PWRITE        (PWRITE),
    .PWDATA        (PWDATA),
    .PSELx         (PSELx),
    .PENABLE       (PENABLE),
    .PRDATA        (PRDATA),
    .PREADY        (PREADY),
    .PSLVERR       (PSLVERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic issue(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd);
    i_cmd_valid = 1'b1;
    i_cmd_addr  = addr;
    i_cmd_write = wr;
    i_cmd_wdata = wd;
    step();
    i_cmd_valid = 1'b0;
    i_cmd_addr  = 32'hFFFF_FFFF;
    i_cmd_wdata = 32'hFFFF_FFFF;
  endtask

  initial begin
    i_reset_n   = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_write = 1'b0;
    i_cmd_wdata = '0;
    i_rsp_ready = 1'b0;
    PRDATA      = '0;
    PREADY      = 1'b0;
    PSLVERR     = 1'b0;

    // ---- reset state
    step(); step();
    chk("rst_psel",   PSELx, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr",  PADDR, 0);
    chk("rst_rvalid", o_rsp_valid, 0);
    chk("rst_cready", o_cmd_ready, 0);
    i_reset_n = 1'b1;
    step();
    chk("idle_cready", o_cmd_ready, 1);

    // ---- zero-wait write, then hold the response for 5 cycles
    PREADY = 1'b1;
    issue(32'h4, 1'b1, 32'hDEAD_BEEF);
    chk("w_setup_psel",  PSELx, 1);
    chk("w_setup_pen",   PENABLE, 0);
    chk("w_setup_paddr", PADDR, 32'h4);
    chk("w_setup_pwd",   PWDATA, 32'hDEAD_BEEF);
    chk("w_setup_pwr",   PWRITE, 1);
    chk("w_setup_cready", o_cmd_ready, 0);
    step();
    chk("w_acc_psel",  PSELx, 1);
    chk("w_acc_pen",   PENABLE, 1);
    chk("w_acc_paddr", PADDR, 32'h4);
    chk("w_acc_pwd",   PWDATA, 32'hDEAD_BEEF);
    step();
    chk("w_rsp_valid", o_rsp_valid, 1);
    chk("w_rsp_err",   o_rsp_err, 0);
    chk("w_rsp_rdata", o_rsp_rdata, 0);
    chk("w_rsp_to",    o_rsp_timeout, 0);
    chk("w_rsp_psel",  PSELx, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid",  o_rsp_valid, 1);
      chk("bp_err",    o_rsp_err, 0);
      chk("bp_cready", o_cmd_ready, 0);
      chk("bp_psel",   PSELx, 0);
    end
    i_rsp_ready = 1'b1;
    step();
    chk("bp_done_valid",  o_rsp_valid, 0);
    chk("bp_done_cready", o_cmd_ready, 1);
    chk("retain_paddr",   PADDR, 32'h4);
    chk("retain_pwdata",  PWDATA, 32'hDEAD_BEEF);

    // ---- read with 3 wait states; PRDATA is garbage until the PREADY edge
    PREADY = 1'b0;
    PRDATA = 32'hBAD0_BAD0;
    issue(32'h8, 1'b0, 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("r_wait_pen",   PENABLE, 1);
      chk("r_wait_paddr", PADDR, 32'h8);
      chk("r_wait_pwr",   PWRITE, 0);
      if (i == 3) begin
        PREADY = 1'b1;
        PRDATA = 32'h1234_5678;
      end
      step();
    end
    PRDATA = 32'h0BAD_F00D;
    chk("r_rsp_valid", o_rsp_valid, 1);
    chk("r_rsp_rdata", o_rsp_rdata, 32'h1234_5678);
    chk("r_rsp_err",   o_rsp_err, 0);
    chk("r_rsp_pen",   PENABLE, 0);
    step();

    // ---- slave error on a read
    PREADY  = 1'b1;
    PSLVERR = 1'b1;
    PRDATA  = 32'hA5A5_0040;
    issue(32'h40, 1'b0, 32'h0);
    step(); step();
    chk("e_rsp_valid", o_rsp_valid, 1);
    chk("e_rsp_err",   o_rsp_err, 1);
    chk("e_rsp_to",    o_rsp_timeout, 0);
    chk("e_rsp_rdata", o_rsp_rdata, 32'hA5A5_0040);
    PSLVERR = 1'b0;
    step();

    // ---- timeout: PREADY held low
    PREADY = 1'b0;
    PRDATA = 32'h7777_7777;
    issue(32'h10, 1'b0, 32'h0);
    step();
    n_access = 0;
    for (int i = 0; i < 40 && PENABLE === 1'b1; i++) begin
      n_access++;
      step();
    end
    chk("to_access_cycles", n_access, 16);
    chk("to_psel",      PSELx, 0);
    chk("to_rsp_valid", o_rsp_valid, 1);
    chk("to_rsp_err",   o_rsp_err, 1);
    chk("to_rsp_to",    o_rsp_timeout, 1);
    chk("to_rsp_rdata", o_rsp_rdata, 0);
    step();
    chk("to_cready", o_cmd_ready, 1);

    // ---- reset during the second wait state
    issue(32'h20, 1'b1, 32'h0000_0055);
    step();
    chk("rm_wait1_pen", PENABLE, 1);
    step();
    chk("rm_wait2_pen", PENABLE, 1);
    #2 i_reset_n = 1'b0;
    #1;
    chk("rm_psel",   PSELx, 0);
    chk("rm_pen",    PENABLE, 0);
    chk("rm_paddr",  PADDR, 0);
    chk("rm_cready", o_cmd_ready, 0);
    PREADY = 1'b1;
    step();
    chk("rm_hold_valid", o_rsp_valid, 0);
    i_reset_n = 1'b1;
    step();
    chk("rm_post_valid",  o_rsp_valid, 0);
    chk("rm_post_cready", o_cmd_ready, 1);
    issue(32'h24, 1'b1, 32'hCAFE_0001);
    chk("rm_w_psel", PSELx, 1);
    step();
    chk("rm_w_paddr", PADDR, 32'h24);
    chk("rm_w_pwd",   PWDATA, 32'hCAFE_0001);
    step();
    chk("rm_w_valid", o_rsp_valid, 1);
    chk("rm_w_err",   o_rsp_err, 0);
    chk("rm_w_rdata", o_rsp_rdata, 0);
    step();
    chk("rm_w_idle", o_cmd_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
